// File: rtl/split_bus_arbiter_pkg.sv
// Shared constants and types for the two-master / three-slave split-bus arbiter.
// Interconnect muxes and masters import this package for the slave and master codes.
package split_bus_arbiter_pkg;

  localparam int unsigned ARB_SLAVE_LEN  = 2;
  localparam int unsigned ARB_NUM_SLAVES = 3;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_M1_BUSY = 2'd1,
    ST_M2_BUSY = 2'd2
  } arb_state_e;

  // Master ids; the same value drives the address/data mux select
  localparam logic MID_M1 = 1'b0;
  localparam logic MID_M2 = 1'b1;

  // Slave codes
  localparam logic [ARB_SLAVE_LEN-1:0] SLAVE_0 = 2'd0;
  localparam logic [ARB_SLAVE_LEN-1:0] SLAVE_1 = 2'd1;
  localparam logic [ARB_SLAVE_LEN-1:0] SLAVE_2 = 2'd2;

endpackage

// File: rtl/split_bus_arbiter_split_tracker.sv
// Split record for the arbiter: remembers one parked transaction (master, slave),
// and derives per-master eligibility and the resume condition from it.
module split_tracker
  import split_bus_arbiter_pkg::*;
#(
  parameter int unsigned SLAVE_LEN  = ARB_SLAVE_LEN,
  parameter int unsigned NUM_SLAVES = ARB_NUM_SLAVES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_set,
  input  logic                  i_clear,
  input  logic                  i_set_master,
  input  logic [SLAVE_LEN-1:0]  i_set_slave,
  input  logic [NUM_SLAVES-1:0] i_split_en,
  input  logic [SLAVE_LEN-1:0]  i_m1_sel,
  input  logic [SLAVE_LEN-1:0]  i_m2_sel,
  output logic                  o_split_valid,
  output logic                  o_split_master,
  output logic [SLAVE_LEN-1:0]  o_split_slave,
  output logic                  o_m1_elig,
  output logic                  o_m2_elig,
  output logic                  o_resume
);

  logic                 r_split_valid;
  logic                 r_split_master;
  logic [SLAVE_LEN-1:0] r_split_slave;

  // Record a split on request from the FSM; clear it when the parked master resumes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_split_valid  <= 1'b0;
      r_split_master <= 1'b0;
      r_split_slave  <= '0;
    end else if (i_set) begin
      r_split_valid  <= 1'b1;
      r_split_master <= i_set_master;
      r_split_slave  <= i_set_slave;
    end else if (i_clear) begin
      r_split_valid  <= 1'b0;
    end
  end

  // A master is eligible if its code is a real slave and it does not collide with the parked split
  always_comb begin
    o_m1_elig = (32'(i_m1_sel) < NUM_SLAVES) &&
                !(r_split_valid && ((r_split_master == MID_M1) || (i_m1_sel == r_split_slave)));
    o_m2_elig = (32'(i_m2_sel) < NUM_SLAVES) &&
                !(r_split_valid && ((r_split_master == MID_M2) || (i_m2_sel == r_split_slave)));
    o_resume  = r_split_valid && !i_split_en[r_split_slave];
  end

  assign o_split_valid  = r_split_valid;
  assign o_split_master = r_split_master;
  assign o_split_slave  = r_split_slave;

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master, three-slave bus arbiter with split-transaction parking and resume.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module split_bus_arbiter
  import split_bus_arbiter_pkg::*;
#(
  parameter int unsigned SLAVE_LEN  = ARB_SLAVE_LEN,
  parameter int unsigned NUM_SLAVES = ARB_NUM_SLAVES,
  parameter int unsigned MAX_COUNT  = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_request,
  input  logic                  m2_request,
  input  logic [SLAVE_LEN-1:0]  m1_slave_sel,
  input  logic [SLAVE_LEN-1:0]  m2_slave_sel,
  input  logic                  trans_done,
  input  logic [NUM_SLAVES-1:0] split_en,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  bus_busy,
  output logic                  arbiter_busy,
  output logic                  master_sel,
  output logic [SLAVE_LEN-1:0]  slave_sel,
  output logic                  split_pending,
  output logic                  timeout_err
);

  arb_state_e           r_state;
  logic                 r_m1_grant;
  logic                 r_m2_grant;
  logic                 r_bus_busy;
  logic                 r_arbiter_busy;
  logic                 r_master_sel;
  logic [SLAVE_LEN-1:0] r_slave_sel;

  logic                 w_split_valid;
  logic                 w_split_master;
  logic [SLAVE_LEN-1:0] w_split_slave;
  logic                 w_m1_elig;
  logic                 w_m2_elig;
  logic                 w_resume;

  logic w_idle_st;
  logic w_busy_st;
  logic w_split_hit;
  logic w_split_set;
  logic w_timeout;
  logic w_release;
  logic w_resume_go;
  logic w_m1_go;
  logic w_m2_go;
  logic w_busy_nxt;
  logic w_split_valid_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;
`endif

  split_tracker #(
    .SLAVE_LEN  (SLAVE_LEN),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_split_tracker (
    .clk            (clk),
    .reset          (reset),
    .i_set          (w_split_set),
    .i_clear        (w_resume_go),
    .i_set_master   (r_master_sel),
    .i_set_slave    (r_slave_sel),
    .i_split_en     (split_en),
    .i_m1_sel       (m1_slave_sel),
    .i_m2_sel       (m2_slave_sel),
    .o_split_valid  (w_split_valid),
    .o_split_master (w_split_master),
    .o_split_slave  (w_split_slave),
    .o_m1_elig      (w_m1_elig),
    .o_m2_elig      (w_m2_elig),
    .o_resume       (w_resume)
  );

  // Arbitration decisions: resume > m1 > m2 in IDLE; trans_done > split > timeout when busy
  always_comb begin
    w_idle_st   = (r_state == ST_IDLE);
    w_busy_st   = (r_state == ST_M1_BUSY) || (r_state == ST_M2_BUSY);
    w_split_hit = split_en[r_slave_sel];
    w_split_set = w_busy_st && !trans_done && w_split_hit && !w_split_valid;
    w_timeout   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_timeout   = w_busy_st && !trans_done && !w_split_set &&
                  (r_cnt == CNT_W'(MAX_COUNT - 1));
`endif
    w_release   = w_busy_st && (trans_done || w_split_set || w_timeout);
    w_resume_go = w_idle_st && w_resume;
    w_m1_go     = w_idle_st && !w_resume && m1_request && w_m1_elig;
    w_m2_go     = w_idle_st && !w_resume && !w_m1_go && m2_request && w_m2_elig;
    w_busy_nxt  = (w_busy_st && !w_release) || w_resume_go || w_m1_go || w_m2_go;
    w_split_valid_nxt = (w_split_valid && !w_resume_go) || w_split_set;
  end

  // Grant FSM with registered grant, busy and mux-select outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_m1_grant     <= 1'b0;
      r_m2_grant     <= 1'b0;
      r_bus_busy     <= 1'b0;
      r_arbiter_busy <= 1'b0;
      r_master_sel   <= 1'b0;
      r_slave_sel    <= '0;
    end else begin
      r_bus_busy     <= w_busy_nxt;
      r_arbiter_busy <= w_busy_nxt || w_split_valid_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_resume_go) begin
            r_state      <= (w_split_master == MID_M2) ? ST_M2_BUSY : ST_M1_BUSY;
            r_m1_grant   <= (w_split_master == MID_M1);
            r_m2_grant   <= (w_split_master == MID_M2);
            r_master_sel <= w_split_master;
            r_slave_sel  <= w_split_slave;
          end else if (w_m1_go) begin
            r_state      <= ST_M1_BUSY;
            r_m1_grant   <= 1'b1;
            r_master_sel <= MID_M1;
            r_slave_sel  <= m1_slave_sel;
          end else if (w_m2_go) begin
            r_state      <= ST_M2_BUSY;
            r_m2_grant   <= 1'b1;
            r_master_sel <= MID_M2;
            r_slave_sel  <= m2_slave_sel;
          end
        end
        ST_M1_BUSY, ST_M2_BUSY: begin
          if (w_release) begin
            r_state    <= ST_IDLE;
            r_m1_grant <= 1'b0;
            r_m2_grant <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_m1_grant <= 1'b0;
          r_m2_grant <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Grant watchdog: counts busy cycles since the grant, pulses timeout_err on forced release
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (!w_busy_st || w_release) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign m1_grant      = r_m1_grant;
  assign m2_grant      = r_m2_grant;
  assign bus_busy      = r_bus_busy;
  assign arbiter_busy  = r_arbiter_busy;
  assign master_sel    = r_master_sel;
  assign slave_sel     = r_slave_sel;
  assign split_pending = w_split_valid;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Directed scoreboard bench for split_bus_arbiter; timeout steps follow ARB_TIMEOUT_EN.
module tb_split_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       m1_request;
  logic       m2_request;
  logic [1:0] m1_slave_sel;
  logic [1:0] m2_slave_sel;
  logic       trans_done;
  logic [2:0] split_en;
  logic       m1_grant;
  logic       m2_grant;
  logic       bus_busy;
  logic       arbiter_busy;
  logic       master_sel;
  logic [1:0] slave_sel;
  logic       split_pending;
  logic       timeout_err;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_cmp;
  int       n_fail;

  split_bus_arbiter #(
    .SLAVE_LEN  (2),
    .NUM_SLAVES (3),
    .MAX_COUNT  (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m1_request    (m1_request),
    .m2_request    (m2_request),
    .m1_slave_sel  (m1_slave_sel),
    .m2_slave_sel  (m2_slave_sel),
    .trans_done    (trans_done),
    .split_en      (split_en),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .bus_busy      (bus_busy),
    .arbiter_busy  (arbiter_busy),
    .master_sel    (master_sel),
    .slave_sel     (slave_sel),
    .split_pending (split_pending),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector {m1g, m2g, bus_busy, arb_busy, master_sel, slave_sel[1:0], split_pending, timeout_err}
  function automatic logic [8:0] ev(input logic g1, input logic g2, input logic bb, input logic ab,
                                    input logic ms, input logic [1:0] ss, input logic sp, input logic to);
    return {g1, g2, bb, ab, ms, ss, sp, to};
  endfunction

  // Push the expectation for the inputs just driven, clock once, then pop and compare
  task automatic cyc(input string tag, input logic [8:0] e);
    sb_item_t   it;
    logic [8:0] obs;
    sb_q.push_back('{tag: tag, exp: e});
    @(posedge clk);
    #1;
    it  = sb_q.pop_front();
    obs = {m1_grant, m2_grant, bus_busy, arbiter_busy, master_sel, slave_sel, split_pending, timeout_err};
    n_cmp++;
    assert (obs === it.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", it.tag, obs, it.exp);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    m1_request   = 1'b0;
    m2_request   = 1'b0;
    m1_slave_sel = 2'd0;
    m2_slave_sel = 2'd0;
    trans_done   = 1'b0;
    split_en     = 3'b000;
    cyc("reset", ev(0,0,0,0,0,2'd0,0,0));
    reset = 1'b0;

    // Basic grant and release
    m1_request = 1'b1; m1_slave_sel = 2'd1;
    cyc("m1_grant", ev(1,0,1,1,0,2'd1,0,0));
    m1_request = 1'b0;
    cyc("m1_hold_req_low", ev(1,0,1,1,0,2'd1,0,0));
    trans_done = 1'b1;
    cyc("m1_done", ev(0,0,0,0,0,2'd1,0,0));
    trans_done = 1'b0;

    // Simultaneous requests: m1 first, then m2 after one idle cycle
    m1_request = 1'b1; m1_slave_sel = 2'd0;
    m2_request = 1'b1; m2_slave_sel = 2'd2;
    cyc("both_req_m1_wins", ev(1,0,1,1,0,2'd0,0,0));
    trans_done = 1'b1; m1_request = 1'b0;
    cyc("m1_done_idle_gap", ev(0,0,0,0,0,2'd0,0,0));
    trans_done = 1'b0;
    cyc("m2_grant", ev(0,1,1,1,1,2'd2,0,0));
    trans_done = 1'b1; m2_request = 1'b0;
    cyc("m2_done", ev(0,0,0,0,1,2'd2,0,0));
    trans_done = 1'b0;

    // Split on slave 1, m1 held off then granted on slave 0, m2 resumed
    m2_request = 1'b1; m2_slave_sel = 2'd1;
    cyc("m2_grant_s1", ev(0,1,1,1,1,2'd1,0,0));
    m2_request = 1'b0; split_en = 3'b010;
    cyc("m2_split", ev(0,0,0,1,1,2'd1,1,0));
    m1_request = 1'b1; m1_slave_sel = 2'd1;
    cyc("m1_blocked_s1", ev(0,0,0,1,1,2'd1,1,0));
    m2_request = 1'b1;
    cyc("both_blocked", ev(0,0,0,1,1,2'd1,1,0));
    m2_request = 1'b0; m1_slave_sel = 2'd0;
    cyc("m1_grant_s0", ev(1,0,1,1,0,2'd0,1,0));
    split_en = 3'b000;
    cyc("m1_busy_split_clear", ev(1,0,1,1,0,2'd0,1,0));
    split_en = 3'b001;
    cyc("second_split_ignored", ev(1,0,1,1,0,2'd0,1,0));
    split_en = 3'b000; trans_done = 1'b1; m1_request = 1'b0;
    cyc("m1_done_pending", ev(0,0,0,1,0,2'd0,1,0));
    trans_done = 1'b0;
    cyc("m2_resume", ev(0,1,1,1,1,2'd1,0,0));

    // trans_done and split in the same cycle: done wins
    split_en = 3'b010; trans_done = 1'b1;
    cyc("done_beats_split", ev(0,0,0,0,1,2'd1,0,0));
    split_en = 3'b000; trans_done = 1'b0;

    // Invalid slave code is never granted
    m1_request = 1'b1; m1_slave_sel = 2'd3;
    cyc("bad_code_1", ev(0,0,0,0,1,2'd1,0,0));
    cyc("bad_code_2", ev(0,0,0,0,1,2'd1,0,0));
    m1_request = 1'b0;

    // Reset while M1_BUSY with a split pending
    m2_request = 1'b1; m2_slave_sel = 2'd2;
    cyc("m2_grant_s2", ev(0,1,1,1,1,2'd2,0,0));
    m2_request = 1'b0; split_en = 3'b100;
    cyc("m2_split_s2", ev(0,0,0,1,1,2'd2,1,0));
    m1_request = 1'b1; m1_slave_sel = 2'd0;
    cyc("m1_grant_pending", ev(1,0,1,1,0,2'd0,1,0));
    reset = 1'b1;
    cyc("reset_busy", ev(0,0,0,0,0,2'd0,0,0));
    reset = 1'b0; m1_request = 1'b0; split_en = 3'b000;
    cyc("post_reset_no_resume", ev(0,0,0,0,0,2'd0,0,0));

    // Long ownership: forced release with the timeout, otherwise held indefinitely
    m1_request = 1'b1; m1_slave_sel = 2'd2;
    cyc("m1_grant_long", ev(1,0,1,1,0,2'd2,0,0));
    m1_request = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) cyc($sformatf("to_hold_%0d", i), ev(1,0,1,1,0,2'd2,0,0));
    cyc("to_release", ev(0,0,0,0,0,2'd2,0,1));
    cyc("to_pulse_end", ev(0,0,0,0,0,2'd2,0,0));
`else
    for (int i = 0; i < 12; i++) cyc($sformatf("hold_%0d", i), ev(1,0,1,1,0,2'd2,0,0));
    trans_done = 1'b1;
    cyc("long_done", ev(0,0,0,0,0,2'd2,0,0));
    trans_done = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
